// File: rtl/mem_req_responder_if.sv
// Request-channel types and the mem_req_if bundle shared by request masters
// and memory-side responders.
package mem_req_pkg;
  localparam int PADDR_W = 40;
  typedef logic [PADDR_W-1:0] paddr_t;
  typedef logic [7:0]         msg_type_t;
  localparam msg_type_t MSG_TYPE_LOAD_REQ  = 8'd19;
  localparam msg_type_t MSG_TYPE_STORE_REQ = 8'd20;
endpackage

interface mem_req_if;
  import mem_req_pkg::*;
  logic        valid;
  logic        ready;
  msg_type_t   req_type;
  logic [1:0]  size;
  paddr_t      address;
  logic [7:0]  mshrid;
  logic [7:0]  write_mask;
  logic [31:0] data_0;
  logic [31:0] data_1;
  logic [7:0]  homeid;

  modport master (output valid, req_type, size, address, mshrid, write_mask,
                         data_0, data_1, homeid,
                  input  ready);
  modport slave  (input  valid, req_type, size, address, mshrid, write_mask,
                         data_0, data_1, homeid,
                  output ready);
endinterface

// File: rtl/mem_req_responder.sv
// Scratchpad responder: services load/store requests from a flop array and
// returns one in-order response per accepted request through a small FIFO.
module mem_req_responder
  import mem_req_pkg::*;
#(
  parameter int DEPTH_WORDS     = 256,
  parameter int RESP_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_req_if.slave    mem_req,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [7:0]  resp_mshrid,
  output logic [63:0] resp_data,
  output logic        resp_err
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int PTR_W = $clog2(RESP_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [63:0] mem_q [DEPTH_WORDS];
  logic [7:0]  fifo_mshr_q [RESP_FIFO_DEPTH];
  logic [63:0] fifo_data_q [RESP_FIFO_DEPTH];
  logic        fifo_err_q  [RESP_FIFO_DEPTH];

  logic             alive_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  paddr_t           addr;
  logic [IDX_W-1:0] word_idx;
  logic             half_sel, out_of_range, is_load, is_store, is_full, req_err;
  logic             accept, pop;
  logic [63:0]      rd_word, load_data, wr_data, push_data;
  logic [7:0]       size_be, byte_we;
  logic             unused_bits;

  // alive_q keeps ready low until the first edge after reset release.
  assign mem_req.ready = alive_q && (count_q < CNT_W'(RESP_FIFO_DEPTH));
  assign accept        = mem_req.valid && mem_req.ready;
  assign resp_valid    = (count_q != '0);
  assign pop           = resp_valid && resp_ready;
  assign unused_bits   = ^{addr[1:0], mem_req.homeid};

  always_comb begin
    addr         = mem_req.address;
    word_idx     = addr[3 +: IDX_W];
    half_sel     = addr[2];
    out_of_range = |addr[PADDR_W-1:3+IDX_W];
    is_load      = (mem_req.req_type == MSG_TYPE_LOAD_REQ);
    is_store     = (mem_req.req_type == MSG_TYPE_STORE_REQ);
    is_full      = (mem_req.size == 2'h1);
    req_err      = !(is_load || is_store) || out_of_range || mem_req.size[1];
    rd_word      = mem_q[word_idx];
    load_data    = is_full ? rd_word
                           : {32'h0, half_sel ? rd_word[63:32] : rd_word[31:0]};
    size_be      = is_full ? 8'hFF : (half_sel ? 8'hF0 : 8'h0F);
    // A 4-byte store lands data_0 in whichever half is selected.
    wr_data      = is_full ? {mem_req.data_1, mem_req.data_0}
                           : {mem_req.data_0, mem_req.data_0};
    push_data    = (is_load && !req_err) ? load_data : 64'h0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_byte_we
      assign byte_we[gi] = accept && is_store && !req_err
                           && mem_req.write_mask[gi] && size_be[gi];
    end
  endgenerate

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(accept);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      alive_q  <= 1'b1;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately unreset; validity is carried by count_q.
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_mshr_q[wr_ptr_q] <= mem_req.mshrid;
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_err_q[wr_ptr_q]  <= req_err;
    end
    for (int b = 0; b < 8; b++) begin
      if (byte_we[b]) mem_q[word_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

  assign resp_mshrid = resp_valid ? fifo_mshr_q[rd_ptr_q] : 8'h0;
  assign resp_data   = resp_valid ? fifo_data_q[rd_ptr_q] : 64'h0;
  assign resp_err    = resp_valid ? fifo_err_q[rd_ptr_q]  : 1'b0;
endmodule

// File: tb/tb_mem_req_responder.sv
// Randomised and directed checks of mem_req_responder against a byte-level
// scratchpad model and an expected-response queue.
module tb_mem_req_responder;
  import mem_req_pkg::*;
  localparam int DEPTH = 256;
  localparam int IDX   = $clog2(DEPTH);

  typedef struct {
    logic [7:0]  id;
    logic [63:0] data;
    logic        err;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        resp_ready = 1'b0;
  logic        resp_valid;
  logic [7:0]  resp_mshrid;
  logic [63:0] resp_data;
  logic        resp_err;

  mem_req_if req_if();

  mem_req_responder #(.DEPTH_WORDS(DEPTH), .RESP_FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req    (req_if),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_mshrid(resp_mshrid),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  resp_t       exp_q[$];
  resp_t       mon_e;
  logic [63:0] mdl [DEPTH];
  int          n_compared = 0;
  int          n_mismatched = 0;
  bit          rand_rr = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: what the scratchpad should hold and answer for one request.
  task automatic model_req(input msg_type_t t, input logic [1:0] sz, input paddr_t a,
                           input logic [7:0] id, input logic [7:0] m,
                           input logic [31:0] d0, input logic [31:0] d1);
    resp_t       r;
    int          w;
    int          h;
    logic [63:0] word;
    logic [63:0] full;
    w = int'(a[3 +: IDX]);
    h = int'(a[2]);
    r.id = id; r.data = 64'h0; r.err = 1'b0;
    if ((t != MSG_TYPE_LOAD_REQ && t != MSG_TYPE_STORE_REQ) || (a >> (3 + IDX)) != 0 || sz > 2'd1) begin
      r.err = 1'b1;
    end else if (t == MSG_TYPE_LOAD_REQ) begin
      word = mdl[w];
      if (sz == 2'd1) r.data = word;
      else            r.data = (h == 1) ? {32'h0, word[63:32]} : {32'h0, word[31:0]};
    end else begin
      full = {d1, d0};
      for (int i = 0; i < 8; i++) begin
        if (m[i] && (sz == 2'd1 || (i / 4) == h)) begin
          if (sz == 2'd1) mdl[w][8*i +: 8] = full[8*i +: 8];
          else            mdl[w][8*i +: 8] = d0[8*(i % 4) +: 8];
        end
      end
    end
    exp_q.push_back(r);
  endtask

  task automatic drive(input msg_type_t t, input logic [1:0] sz, input paddr_t a,
                       input logic [7:0] id, input logic [7:0] m,
                       input logic [31:0] d0, input logic [31:0] d1);
    req_if.valid      = 1'b1;
    req_if.req_type   = t;
    req_if.size       = sz;
    req_if.address    = a;
    req_if.mshrid     = id;
    req_if.write_mask = m;
    req_if.data_0     = d0;
    req_if.data_1     = d1;
    req_if.homeid     = 8'($urandom);
  endtask

  // Present a request and hold it until accepted (bounded).
  task automatic send(input msg_type_t t, input logic [1:0] sz, input paddr_t a,
                      input logic [7:0] id, input logic [7:0] m,
                      input logic [31:0] d0, input logic [31:0] d1);
    int waited;
    waited = 0;
    drive(t, sz, a, id, m, d0, d1);
    forever begin
      if (rand_rr) resp_ready = 1'($urandom_range(0, 1));
      if (req_if.ready) begin
        model_req(t, sz, a, id, m, d0, d1);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      waited++;
      if (waited > 50) begin
        check("req_accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  task automatic idle();
    req_if.valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    resp_ready = 1'b1;
    while (exp_q.size() != 0 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        check("stale_resp", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("resp id=%0d data=%h err=%0d", resp_mshrid, resp_data, resp_err);
        check("resp_mshrid", 64'(resp_mshrid), 64'(mon_e.id));
        check("resp_data", resp_data, mon_e.data);
        check("resp_err", 64'(resp_err), 64'(mon_e.err));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int r;
    logic [1:0] sz;
    paddr_t a;
    msg_type_t t;

    idle();
    drive(MSG_TYPE_LOAD_REQ, 2'd1, '0, 8'd0, 8'd0, 32'd0, 32'd0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(req_if.ready), 64'd0);
    check("rst_valid", 64'(resp_valid), 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 64'(req_if.ready), 64'd1);
    check("valid_after_rst", 64'(resp_valid), 64'd0);

    // Prefill every word so later loads have defined contents.
    resp_ready = 1'b1;
    for (int w = 0; w < DEPTH; w++)
      send(MSG_TYPE_STORE_REQ, 2'd1, paddr_t'(w) << 3, 8'(w), 8'hFF, $urandom, $urandom);
    idle();
    drain();

    // Store then load, with one-cycle response latency.
    resp_ready = 1'b0;
    send(MSG_TYPE_STORE_REQ, 2'd1, 'h10, 8'd145, 8'hFF, 32'hdeadbeef, 32'hbeefdead);
    idle();
    check("lat_valid", 64'(resp_valid), 64'd1);
    check("lat_mshrid", 64'(resp_mshrid), 64'd145);
    send(MSG_TYPE_LOAD_REQ, 2'd1, 'h10, 8'd7, 8'h00, 32'h0, 32'h0);
    idle();
    drain();
    check("store_load_word", mdl[2], 64'hbeefdead_deadbeef);

    // Partial stores.
    send(MSG_TYPE_STORE_REQ, 2'd1, 'h20, 8'd1, 8'hFF, 32'h55667788, 32'h11223344);
    send(MSG_TYPE_STORE_REQ, 2'd0, 'h24, 8'd2, 8'hFF, 32'hAABBCCDD, 32'h0);
    send(MSG_TYPE_STORE_REQ, 2'd1, 'h20, 8'd3, 8'h01, 32'h000000EE, 32'h0);
    send(MSG_TYPE_LOAD_REQ,  2'd1, 'h20, 8'd4, 8'h00, 32'h0, 32'h0);
    send(MSG_TYPE_LOAD_REQ,  2'd0, 'h24, 8'd5, 8'h00, 32'h0, 32'h0);
    idle();
    drain();

    // Backpressure: six back-to-back loads with the consumer stalled.
    resp_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      drive(MSG_TYPE_LOAD_REQ, 2'd1, paddr_t'(8 * k), 8'(k), 8'h00, 32'h0, 32'h0);
      if (req_if.ready) begin
        model_req(MSG_TYPE_LOAD_REQ, 2'd1, paddr_t'(8 * k), 8'(k), 8'h00, 32'h0, 32'h0);
        k++;
      end
      @(posedge clk); #1;
    end
    check("bp_accepted", 64'(k), 64'd4);
    check("bp_ready_low", 64'(req_if.ready), 64'd0);
    resp_ready = 1'b1;
    check("bp_ready_same_cycle", 64'(req_if.ready), 64'd0);
    @(posedge clk); #1;
    check("bp_ready_after_pop", 64'(req_if.ready), 64'd1);
    send(MSG_TYPE_LOAD_REQ, 2'd1, 'h20, 8'd4, 8'h00, 32'h0, 32'h0);
    send(MSG_TYPE_LOAD_REQ, 2'd1, 'h28, 8'd5, 8'h00, 32'h0, 32'h0);
    idle();
    drain();

    // Errors leave the array untouched.
    send(MSG_TYPE_LOAD_REQ,  2'd1, 'h800, 8'd60, 8'h00, 32'h0, 32'h0);
    send(8'hA5,              2'd1, 'h30,  8'd61, 8'hFF, 32'h1, 32'h2);
    send(MSG_TYPE_STORE_REQ, 2'd3, 'h30,  8'd62, 8'hFF, 32'h12345678, 32'h9abcdef0);
    send(MSG_TYPE_LOAD_REQ,  2'd1, 'h30,  8'd63, 8'h00, 32'h0, 32'h0);
    idle();
    drain();

    // Back-to-back read-after-write with consecutive responses.
    send(MSG_TYPE_STORE_REQ, 2'd1, 'h50, 8'd70, 8'hFF, $urandom, $urandom);
    check("raw_valid0", 64'(resp_valid), 64'd1);
    check("raw_id0", 64'(resp_mshrid), 64'd70);
    send(MSG_TYPE_LOAD_REQ, 2'd1, 'h50, 8'd71, 8'h00, 32'h0, 32'h0);
    idle();
    check("raw_valid1", 64'(resp_valid), 64'd1);
    check("raw_id1", 64'(resp_mshrid), 64'd71);
    drain();

    // Random traffic with random consumer stalls.
    rand_rr = 1'b1;
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 9));
      t = (r < 4) ? MSG_TYPE_LOAD_REQ : (r < 8) ? MSG_TYPE_STORE_REQ : 8'($urandom_range(21, 255));
      sz = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      a = paddr_t'($urandom_range(0, (8 * DEPTH) - 1));
      if ($urandom_range(0, 19) == 0) a[3 + IDX + $urandom_range(0, 28)] = 1'b1;
      send(t, sz, a, 8'($urandom), 8'($urandom), $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk); #1;
      end
    end
    rand_rr = 1'b0;
    idle();
    drain();

    // Asynchronous reset with three responses queued.
    resp_ready = 1'b0;
    send(MSG_TYPE_LOAD_REQ, 2'd1, 'h10, 8'd80, 8'h00, 32'h0, 32'h0);
    send(MSG_TYPE_LOAD_REQ, 2'd1, 'h18, 8'd81, 8'h00, 32'h0, 32'h0);
    send(MSG_TYPE_LOAD_REQ, 2'd1, 'h20, 8'd82, 8'h00, 32'h0, 32'h0);
    idle();
    check("pre_rst_valid", 64'(resp_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(resp_valid), 64'd0);
    check("arst_mshrid", 64'(resp_mshrid), 64'd0);
    check("arst_data", resp_data, 64'd0);
    check("arst_err", 64'(resp_err), 64'd0);
    check("arst_ready", 64'(req_if.ready), 64'd0);
    exp_q.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_ready", 64'(req_if.ready), 64'd1);
    check("rel_valid", 64'(resp_valid), 64'd0);
    resp_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    send(MSG_TYPE_LOAD_REQ, 2'd1, 'h10, 8'd90, 8'h00, 32'h0, 32'h0);
    idle();
    drain();

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
